fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DWIDTH, default 8: data word width in bits.
REQ-002 Parameter AWIDTH, default 3: address width; storage depth SHALL be 2**AWIDTH words (8 by default).
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset; asserted when low.
REQ-005 dataIn  input  DWIDTH: write data.
REQ-006 rd  input  1: read request.
REQ-007 wr  input  1: write request.
REQ-008 en  input  1: global enable; when low, no read and no write SHALL occur.
REQ-009 dataOut  output  DWIDTH: registered read data.
REQ-010 empty  output  1: high when the FIFO holds zero words.
REQ-011 full  output  1: high when the FIFO holds 2**AWIDTH words.

Function
REQ-012 Storage: 2**AWIDTH x DWIDTH memory, AWIDTH-bit write and read pointers, AWIDTH+1-bit occupancy count (0..2**AWIDTH).
REQ-013 Write accepted on a rising edge iff en=1, wr=1 and (full=0 or a read is accepted on the same edge); dataIn is stored at the write pointer, which then increments.
REQ-014 Read accepted on a rising edge iff en=1, rd=1 and empty=0; the word at the read pointer is loaded into dataOut on that edge (1-cycle latency), and the read pointer increments.
REQ-015 Pointers wrap from 2**AWIDTH-1 to 0 with no gap; full/empty are derived from the count, never from pointer equality alone.
REQ-016 Count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-017 Write while full with no accepted read: ignored; memory, pointers, count unchanged; no error flag.
REQ-018 Read while empty: ignored; dataOut holds its previous value; pointers and count unchanged.
REQ-019 Simultaneous rd and wr while empty: only the write is accepted; dataOut unchanged; count becomes 1.
REQ-020 Simultaneous rd and wr while full: both accepted; dataOut gets the oldest word, new word stored, full stays 1.
REQ-021 empty = (count == 0); full = (count == 2**AWIDTH); both are combinational decodes of the registered count and update the cycle after the causing edge.
REQ-022 dataOut SHALL change only on an accepted read or reset; it holds otherwise, including while en=0.
REQ-023 Words SHALL be read out in exactly the order written.

Reset
REQ-024 While rst=0, immediately and independent of clk: pointers=0, count=0, dataOut=0, empty=1, full=0.
REQ-025 Memory contents need not be cleared; no stale word SHALL be readable after reset since count=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first edge after rst returns high behaves as on an empty FIFO.

Verification
REQ-027 Reset: rst=0 with random rd/wr/en -> dataOut=0x00, empty=1, full=0 throughout.
REQ-028 Fill: en=1, wr=1, dataIn=1..8 over 8 edges -> empty falls after first edge, full=1 after eighth; a ninth write of 0x09 ignored.
REQ-029 Drain: after fill, rd=1 for 9 edges -> dataOut = 1,2,...,8 on successive edges, empty=1 after eighth, ninth read leaves dataOut=8.
REQ-030 Enable gating: en=0 with rd=1, wr=1 for several edges -> count, flags and dataOut unchanged.
REQ-031 Concurrent: from empty write 0x0F, then rd=wr=1 with dataIn=0x0E..0x08 -> dataOut = 0x0F,0x0E,...,0x09 one per edge, count stays 1, finally drain yields 0x08 and empty=1.
REQ-032 Wrap/full-concurrent: fill to 8, then rd=wr=1 for 10 edges -> full stays 1, output order preserved across pointer wrap.

Source files
------------

// File: rtl/fifo.sv
// Synchronous single-clock FIFO, 2**AWIDTH words deep, with a registered read port.
// Full/empty come from an occupancy count, so they stay correct when the pointers wrap.
module fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] dataIn,
  input  logic              rd,
  input  logic              wr,
  input  logic              en,
  output logic [DWIDTH-1:0] dataOut,
  output logic              empty,
  output logic              full
);

  localparam int              DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0]   CNT_ZERO = (AWIDTH+1)'(0);
  localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_count;
  logic [DWIDTH-1:0] r_dout;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [AWIDTH:0]   w_count_nxt;

  // A full FIFO may still accept a write when a read frees a slot on the same edge.
  assign w_rd_acc = en & rd & ~empty;
  assign w_wr_acc = en & wr & (~full | w_rd_acc);

  assign empty   = (r_count == CNT_ZERO);
  assign full    = (r_count == CNT_FULL);
  assign dataOut = r_dout;

  // Next occupancy: simultaneous accepted read and write leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; left uncleared by reset since count=0 hides stale words.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= dataIn;
    end
  end

  // Pointers, occupancy and the registered read word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + PTR_ONE;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + PTR_ONE;
      end else begin
        r_dout <= r_dout;
        r_rptr <= r_rptr;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: reset, fill, drain, enable gating,
// concurrent read/write, pointer wrap while full, and mid-operation reset.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn;
  logic       rd;
  logic       wr;
  logic       en;
  logic [7:0] dataOut;
  logic       empty;
  logic       full;

  int n_cmp;
  int n_err;

  fifo #(.DWIDTH(8), .AWIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .dataIn (dataIn),
    .rd     (rd),
    .wr     (wr),
    .en     (en),
    .dataOut(dataOut),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_dout,
                             input logic e_empty, input logic e_full);
    check({tag, ".dataOut"}, {24'd0, dataOut}, {24'd0, e_dout});
    check({tag, ".empty"},   {31'd0, empty},   {31'd0, e_empty});
    check({tag, ".full"},    {31'd0, full},    {31'd0, e_full});
  endtask

  // Apply inputs just after an edge, then wait for the next edge plus 1 time unit.
  task automatic cyc(input logic e, input logic r, input logic w, input logic [7:0] d);
    en = e; rd = r; wr = w; dataIn = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_d;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; en = 1'b0; rd = 1'b0; wr = 1'b0; dataIn = 8'h00;

    // Reset held with random traffic
    #1;
    check_state("reset0", 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      check_state("reset_hold", 8'h00, 1'b1, 1'b0);
    end
    rst = 1'b1;

    // Fill 1..8, then an ignored ninth write
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(i));
      check_state("fill", 8'h00, 1'b0, (i == 8));
    end
    cyc(1'b1, 1'b0, 1'b1, 8'h09);
    check_state("fill_ovf", 8'h00, 1'b0, 1'b1);

    // Drain 1..8, then a ninth read on empty
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      check_state("drain", 8'(i), (i == 8), 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("drain_udf", 8'h08, 1'b1, 1'b0);

    // Enable gating with two words stored
    cyc(1'b1, 1'b0, 1'b1, 8'hAA);
    cyc(1'b1, 1'b0, 1'b1, 8'hBB);
    check_state("gate_pre", 8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'hCC);
      check_state("gate_off", 8'h08, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("gate_rd1", 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("gate_rd2", 8'hBB, 1'b1, 1'b0);

    // Concurrent read/write holding one word in flight
    cyc(1'b1, 1'b0, 1'b1, 8'h0F);
    check_state("conc_w", 8'hBB, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      exp_d = 8'h0F - 8'(k);
      cyc(1'b1, 1'b1, 1'b1, 8'h0E - 8'(k));
      check_state("conc_rw", exp_d, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("conc_drain", 8'h08, 1'b1, 1'b0);

    // rd+wr while empty: write only
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    check_state("empty_rw", 8'h08, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("empty_rw_rd", 8'h55, 1'b1, 1'b0);

    // Fill, then rd+wr while full across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h20 + 8'(i));
    end
    check_state("wrap_full", 8'h55, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      exp_d = (k < 8) ? (8'h20 + 8'(k)) : (8'h30 + 8'(k - 8));
      cyc(1'b1, 1'b1, 1'b1, 8'h30 + 8'(k));
      check_state("wrap_rw", exp_d, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-operation, between edges
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("post_rst_rd", 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h77);
    check_state("post_rst_w", 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_state("post_rst_r", 8'h77, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
